// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared state encoding for the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage : rst_seq_pkg
`default_nettype wire

// File: rtl/rst_sequencer_sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : STAGES-deep synchroniser chain with async active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : sync_bit
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rst_sequencer
// Description : Multi-domain reset sequencer, lock-qualified staged release.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_OUT       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1000000,
    parameter int STEP_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             resetn_in,
    input  logic             locked_in,
    input  logic             soft_req,
    output logic [N_OUT-1:0] reset,
    output logic [N_OUT-1:0] reset_n,
    output logic             ready,
    output logic             busy
);

    localparam int MAX_CNT = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CNT_W-1:0] c_HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_STEP_LOAD = CNT_W'(STEP_CYCLES);
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(N_OUT - 1);

    logic w_rst_s;
    logic w_lock_s;
    logic w_qual;
    logic w_restart;

    state_t           r_state,  w_state_nx;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nx;
    logic [IDX_W-1:0] r_idx,    w_idx_nx;
    logic [N_OUT-1:0] r_reset,  w_reset_nx;
    logic             r_ready;
    logic             r_busy;

    // Deassertion of the board reset is synchronised by shifting in a constant 1.
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rst (
        .clk   (clk),
        .rst_n (resetn_in),
        .d     (1'b1),
        .q     (w_rst_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk   (clk),
        .rst_n (resetn_in),
        .d     (locked_in),
        .q     (w_lock_s)
    );

    assign w_qual    = w_rst_s & w_lock_s;
    assign w_restart = ~w_qual | soft_req;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_reset_nx = r_reset;
        case (r_state)
            ST_HOLD: begin
                w_reset_nx = '1;
                if (w_restart) begin
                    w_cnt_nx = c_HOLD_LOAD;
                end else if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end else begin
                    w_reset_nx[0] = 1'b0;
                    w_cnt_nx      = c_STEP_LOAD;
                    w_idx_nx      = IDX_W'(1);
                    w_state_nx    = (N_OUT == 1) ? ST_RUN : ST_STEP;
                end
            end
            ST_STEP: begin
                if (w_restart) begin
                    w_state_nx = ST_HOLD;
                    w_cnt_nx   = c_HOLD_LOAD;
                    w_idx_nx   = '0;
                    w_reset_nx = '1;
                end else if (r_cnt == '0) begin
                    w_reset_nx[r_idx] = 1'b0;
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nx = ST_RUN;
                    end else begin
                        w_idx_nx = r_idx + IDX_W'(1);
                        w_cnt_nx = c_STEP_LOAD;
                    end
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (w_restart) begin
                    w_state_nx = ST_HOLD;
                    w_cnt_nx   = c_HOLD_LOAD;
                    w_idx_nx   = '0;
                    w_reset_nx = '1;
                end else begin
                    w_reset_nx = '0;
                end
            end
            default: begin
                w_state_nx = ST_HOLD;
                w_cnt_nx   = c_HOLD_LOAD;
                w_idx_nx   = '0;
                w_reset_nx = '1;
            end
        endcase
    end

    // Flags are registered from the next state so they change on the same edge as reset.
    always_ff @(posedge clk or negedge resetn_in) begin
        if (!resetn_in) begin
            r_state <= ST_HOLD;
            r_cnt   <= c_HOLD_LOAD;
            r_idx   <= '0;
            r_reset <= '1;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_reset <= w_reset_nx;
            r_ready <= (w_state_nx == ST_RUN);
            r_busy  <= (w_state_nx != ST_RUN);
        end
    end

    assign reset   = r_reset;
    assign reset_n = ~r_reset;
    assign ready   = r_ready;
    assign busy    = r_busy;

endmodule : rst_sequencer
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_sequencer
// Description : Directed self-checking bench for rst_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_sequencer;

    logic       clk;
    logic       resetn_in;
    logic       locked_in;
    logic       soft_req;
    logic [2:0] reset;
    logic [2:0] reset_n;
    logic       ready;
    logic       busy;
    logic [0:0] reset1;
    logic [0:0] reset_n1;
    logic       ready1;
    logic       busy1;

    int checks;
    int failures;

    rst_sequencer #(
        .N_OUT(3), .SYNC_STAGES(2), .HOLD_CYCLES(10), .STEP_CYCLES(4)
    ) u_dut (
        .clk       (clk),
        .resetn_in (resetn_in),
        .locked_in (locked_in),
        .soft_req  (soft_req),
        .reset     (reset),
        .reset_n   (reset_n),
        .ready     (ready),
        .busy      (busy)
    );

    rst_sequencer #(
        .N_OUT(1), .SYNC_STAGES(2), .HOLD_CYCLES(0), .STEP_CYCLES(0)
    ) u_dut1 (
        .clk       (clk),
        .resetn_in (resetn_in),
        .locked_in (locked_in),
        .soft_req  (soft_req),
        .reset     (reset1),
        .reset_n   (reset_n1),
        .ready     (ready1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {reset, reset_n, ready, busy} n edges into a sequence whose first release is at edge t0.
    function automatic logic [7:0] exp_vec(int n, int t0);
        logic [2:0] e;
        logic       r;
        e[0] = (n < t0);
        e[1] = (n < t0 + 5);
        e[2] = (n < t0 + 10);
        r    = (n >= t0 + 10);
        return {e, ~e, r, ~r};
    endfunction

    task automatic test_reset();
        resetn_in = 1'b1;
        locked_in = 1'b1;
        soft_req  = 1'b0;
        #1 resetn_in = 1'b0;
        #1;
        checks++;
        if ({reset, reset_n, ready, busy} !== 8'b111_000_01) begin
            failures++;
            $display("FAIL reset_async_assert got=%b want=%b", {reset, reset_n, ready, busy}, 8'b111_000_01);
        end
        checks++;
        if ({reset1, reset_n1, ready1, busy1} !== 4'b1001) begin
            failures++;
            $display("FAIL reset_async_assert_n1 got=%b want=%b", {reset1, reset_n1, ready1, busy1}, 4'b1001);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({reset, reset_n, ready, busy} !== 8'b111_000_01) begin
            failures++;
            $display("FAIL reset_held got=%b want=%b", {reset, reset_n, ready, busy}, 8'b111_000_01);
        end
    endtask

    task automatic test_powerup();
        logic [7:0] ev;
        logic [3:0] ev1;
        @(negedge clk);
        resetn_in = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk);
            #1;
            ev = exp_vec(n, 13);
            checks++;
            if ({reset, reset_n, ready, busy} !== ev) begin
                failures++;
                $display("FAIL powerup edge=%0d got=%b want=%b", n, {reset, reset_n, ready, busy}, ev);
            end
            ev1 = (n < 3) ? 4'b1001 : 4'b0110;
            checks++;
            if ({reset1, reset_n1, ready1, busy1} !== ev1) begin
                failures++;
                $display("FAIL powerup_n1 edge=%0d got=%b want=%b", n, {reset1, reset_n1, ready1, busy1}, ev1);
            end
        end
    endtask

    task automatic test_async_glitch();
        logic [7:0] ev;
        @(negedge clk);
        #2 resetn_in = 1'b0;
        #1;
        checks++;
        if ({reset, reset_n, ready, busy} !== 8'b111_000_01) begin
            failures++;
            $display("FAIL glitch_async got=%b want=%b", {reset, reset_n, ready, busy}, 8'b111_000_01);
        end
        checks++;
        if (reset1 !== 1'b1 || ready1 !== 1'b0) begin
            failures++;
            $display("FAIL glitch_async_n1 got=%b%b want=10", reset1, ready1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn_in = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk);
            #1;
            ev = exp_vec(n, 13);
            checks++;
            if ({reset, reset_n, ready, busy} !== ev) begin
                failures++;
                $display("FAIL glitch_replay edge=%0d got=%b want=%b", n, {reset, reset_n, ready, busy}, ev);
            end
        end
    endtask

    task automatic test_lock_in_hold();
        logic [7:0] ev;
        @(negedge clk);
        resetn_in = 1'b0;
        @(negedge clk);
        resetn_in = 1'b1;
        for (int n = 1; n <= 38; n++) begin
            @(posedge clk);
            #1;
            if (n == 7)  locked_in = 1'b0;
            if (n == 15) locked_in = 1'b1;
            ev = exp_vec(n, 28);
            checks++;
            if ({reset, reset_n, ready, busy} !== ev) begin
                failures++;
                $display("FAIL lock_hold edge=%0d got=%b want=%b", n, {reset, reset_n, ready, busy}, ev);
            end
        end
    endtask

    task automatic test_soft_req();
        logic [7:0] ev;
        @(posedge clk);
        #1 soft_req = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            @(posedge clk);
            #1;
            soft_req = 1'b0;
            ev = exp_vec(n, 12);
            checks++;
            if ({reset, reset_n, ready, busy} !== ev) begin
                failures++;
                $display("FAIL soft_pulse edge=%0d got=%b want=%b", n, {reset, reset_n, ready, busy}, ev);
            end
        end
    endtask

    task automatic test_lock_in_step();
        logic [7:0] ev;
        @(posedge clk);
        #1 soft_req = 1'b1;
        for (int n = 1; n <= 39; n++) begin
            @(posedge clk);
            #1;
            soft_req = 1'b0;
            if (n == 13) locked_in = 1'b0;
            if (n == 16) locked_in = 1'b1;
            ev = (n < 16) ? exp_vec(n, 12) : exp_vec(n, 29);
            checks++;
            if ({reset, reset_n, ready, busy} !== ev) begin
                failures++;
                $display("FAIL lock_step edge=%0d got=%b want=%b", n, {reset, reset_n, ready, busy}, ev);
            end
        end
    endtask

    task automatic test_soft_held();
        logic [7:0] ev;
        @(posedge clk);
        #1 soft_req = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({reset, reset_n, ready, busy} !== 8'b111_000_01) begin
                failures++;
                $display("FAIL soft_held edge=%0d got=%b want=%b", n, {reset, reset_n, ready, busy}, 8'b111_000_01);
            end
        end
        soft_req = 1'b0;
        for (int n = 1; n <= 21; n++) begin
            @(posedge clk);
            #1;
            ev = exp_vec(n, 11);
            checks++;
            if ({reset, reset_n, ready, busy} !== ev) begin
                failures++;
                $display("FAIL soft_release edge=%0d got=%b want=%b", n, {reset, reset_n, ready, busy}, ev);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_powerup();
        test_async_glitch();
        test_lock_in_hold();
        test_soft_req();
        test_lock_in_step();
        test_soft_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rst_sequencer
`default_nettype wire
